gray_counter_n: RTL and testbench
=================================

GRAY_COUNTER_N -- requirements
Module: gray_counter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits; legal range 2..16.
REQ-002 SHALL have parameter SATURATE, default 0; 0 = wrap at terminal, 1 = hold at terminal.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 SHALL have port clr  input  1  synchronous clear to zero.
REQ-008 SHALL have port load  input  1  synchronous load of load_val.
REQ-009 SHALL have port load_val  input  WIDTH  Gray-coded load value.
REQ-010 SHALL have port q  output  WIDTH  registered Gray count.
REQ-011 SHALL have port bin  output  WIDTH  registered binary equivalent of q.
REQ-012 SHALL have port tc  output  1  terminal-count flag, combinational.

Function
REQ-013 Count sequence SHALL be reflected binary Gray: q == bin ^ (bin >> 1) at every clock edge and after reset.
REQ-014 Control priority per edge SHALL be: clr, then load, then en; with none asserted, q and bin hold.
REQ-015 clr=1 SHALL set q=0 and bin=0 on the next edge, regardless of load, en and up.
REQ-016 load=1 with clr=0 SHALL set q=load_val and bin=gray-to-binary(load_val) on the next edge, regardless of en.
REQ-017 en=1 with up=1 SHALL advance to the next Gray code; single-cycle latency, one edge per step.
REQ-018 en=1 with up=0 SHALL step to the previous Gray code.
REQ-019 Each enabled step SHALL change exactly one bit of q; clr and load steps are exempt.
REQ-020 Terminal value SHALL be, for up=1, bin = 2^WIDTH-1 (q = 1 << (WIDTH-1)); for up=0, bin = 0.
REQ-021 tc SHALL equal en & ~clr & ~load & (bin == terminal value for the current up).
REQ-022 With SATURATE=0, an enabled step at the terminal value SHALL wrap: up goes to 0, down goes to 2^WIDTH-1.
REQ-023 With SATURATE=1, an enabled step at the terminal value SHALL hold q and bin; tc SHALL still assert.
REQ-024 A change of up between edges SHALL take effect on the next edge, with no dead cycle.
REQ-025 The bin output SHALL be a register updated in parallel with q, not decoded combinationally from q.

Reset
REQ-026 rst_n=0 SHALL force q=0 and bin=0 immediately, independent of clk.
REQ-027 While rst_n=0, tc SHALL read 0 unless en=1, up=0 and clr=load=0; this follows from REQ-021 with bin=0.
REQ-028 Release of rst_n SHALL take effect on the first rising edge after deassertion; that edge SHALL evaluate normally.
REQ-029 Assertion of rst_n mid-count SHALL abandon the step in progress with no partial update.
REQ-030 No initial blocks SHALL be relied on for state; reset is the only initialisation.

Structure
REQ-031 The shared include file SHALL hold the WIDTH bounds (2, 16) and the mode encodings SATURATE_WRAP=0 and SATURATE_HOLD=1.
REQ-032 Gray-to-binary conversion SHALL be one sub-module, gray2bin (parameter WIDTH, pure combinational prefix XOR).
REQ-033 gray2bin SHALL be reused for the load path; binary-to-Gray SHALL be inline XOR.
REQ-034 Next-state logic SHALL be a single binary adder/subtractor on bin, with q derived from the next binary value.

Verification
REQ-035 WIDTH=8: pulse rst_n low, then en=1, up=1 for 6 edges -> q = 00,01,03,02,06,07,05; bin = 0..6; tc=0 throughout.
REQ-036 WIDTH=8, SATURATE=0: load=1, load_val=0x80, then en=1, up=1 -> tc=1 before the edge, q=0x00, bin=0x00 after; then up=0 -> q=0x80, bin=0xFF.
REQ-037 WIDTH=4, SATURATE=1: load 0x8, en=1, up=1 for 3 edges -> q stays 0x8, bin stays 0xF, tc=1; set up=0 -> q=0x9, bin=0xE.
REQ-038 WIDTH=8: clr=1, load=1, en=1 on the same edge -> q=0; load=1, en=1, up=1, load_val=0x3C -> q=0x3C, bin=0x28.
REQ-039 WIDTH=8: run 600 enabled up edges -> every q transition has Hamming distance 1, q==bin^(bin>>1) every cycle, and tc pulses on edges 255 and 511.
REQ-040 WIDTH=8: rst_n low between edges mid-count at bin=0x41 -> q=0 and bin=0 immediately; first edge after release with en=1, up=1 -> q=0x01.

Source files
------------

// File: rtl/gray_counter_n_pkg.sv
// rtl/gray_counter_n_pkg.sv - shared bounds and mode encodings for gray_counter_n
package gray_counter_n_pkg;

  localparam int GC_WIDTH_MIN = 2;
  localparam int GC_WIDTH_MAX = 16;

  localparam int SATURATE_WRAP = 0;
  localparam int SATURATE_HOLD = 1;

endpackage

// File: rtl/gray_counter_n_gray2bin.sv
// rtl/gray_counter_n_gray2bin.sv - combinational Gray-to-binary prefix XOR
module gray2bin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - up/down Gray counter with parallel binary register
module gray_counter_n
  import gray_counter_n_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = SATURATE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] bin,
  output logic             tc
);

  if (WIDTH < GC_WIDTH_MIN || WIDTH > GC_WIDTH_MAX) begin : g_width_check
    $error("gray_counter_n: WIDTH out of range");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] step_bin;
  logic             at_term;

  gray2bin #(.WIDTH(WIDTH)) u_load_g2b (
    .gray_i (load_val),
    .bin_o  (load_bin)
  );

  assign term_val = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign at_term  = (bin_q == term_val);

  // One adder serves both directions: adding all-ones is a decrement.
  assign delta    = up ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
  assign step_bin = bin_q + delta;

  always_comb begin
    bin_d = bin_q;
    if (clr) begin
      bin_d = '0;
    end else if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (SATURATE == SATURATE_HOLD && at_term) begin
        bin_d = bin_q;
      end else begin
        bin_d = step_bin;
      end
    end
  end

  assign q_d = bin_d ^ (bin_d >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      bin_q <= '0;
    end else begin
      q_q   <= q_d;
      bin_q <= bin_d;
    end
  end

  assign q   = q_q;
  assign bin = bin_q;
  assign tc  = en & ~clr & ~load & at_term;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb/tb_gray_counter_n.sv - directed self-checking bench for gray_counter_n
module tb_gray_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n8, en8, up8, clr8, load8;
  logic [7:0] load_val8, q8, bin8;
  logic       tc8;

  logic       rst_n4, en4, up4, clr4, load4;
  logic [3:0] load_val4, q4, bin4;
  logic       tc4;

  int n_cmp = 0;
  int n_bad = 0;

  gray_counter_n #(.WIDTH(8), .SATURATE(0)) dut8 (
    .clk(clk), .rst_n(rst_n8), .en(en8), .up(up8), .clr(clr8), .load(load8),
    .load_val(load_val8), .q(q8), .bin(bin8), .tc(tc8)
  );

  gray_counter_n #(.WIDTH(4), .SATURATE(1)) dut4 (
    .clk(clk), .rst_n(rst_n4), .en(en4), .up(up4), .clr(clr4), .load(load4),
    .load_val(load_val4), .q(q4), .bin(bin4), .tc(tc4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q [6];
    logic [7:0] prev_q;
    logic [7:0] exp_bin;
    int hd_bad, gray_bad, bin_bad, tc_cnt, tc_first, tc_second;

    exp_q = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05};

    rst_n8 = 1'b0; en8 = 1'b0; up8 = 1'b1; clr8 = 1'b0; load8 = 1'b0; load_val8 = '0;
    rst_n4 = 1'b0; en4 = 1'b0; up4 = 1'b1; clr4 = 1'b0; load4 = 1'b0; load_val4 = '0;
    #3;
    check_eq("rst_q", q8, 8'h00);
    check_eq("rst_bin", bin8, 8'h00);
    check_eq("rst_tc", tc8, 1'b0);
    en8 = 1'b1; up8 = 1'b0;
    #1;
    check_eq("rst_tc_down", tc8, 1'b1);
    en8 = 1'b0; up8 = 1'b1;
    tick();
    check_eq("rst_held_q", q8, 8'h00);
    #2;
    rst_n8 = 1'b1; rst_n4 = 1'b1;

    // basic up count from zero
    en8 = 1'b1; up8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_eq("up_tc", tc8, 1'b0);
      tick();
      check_eq("up_q", q8, exp_q[i]);
      check_eq("up_bin", bin8, i + 1);
    end

    // wrap at the up terminal, then wrap back down
    en8 = 1'b0; load8 = 1'b1; load_val8 = 8'h80;
    tick();
    check_eq("ld80_q", q8, 8'h80);
    check_eq("ld80_bin", bin8, 8'hFF);
    load8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
    #1;
    check_eq("wrap_up_tc", tc8, 1'b1);
    tick();
    check_eq("wrap_up_q", q8, 8'h00);
    check_eq("wrap_up_bin", bin8, 8'h00);
    up8 = 1'b0;
    #1;
    check_eq("wrap_dn_tc", tc8, 1'b1);
    tick();
    check_eq("wrap_dn_q", q8, 8'h80);
    check_eq("wrap_dn_bin", bin8, 8'hFF);

    // control priority
    clr8 = 1'b1; load8 = 1'b1; en8 = 1'b1; up8 = 1'b1; load_val8 = 8'h3C;
    #1;
    check_eq("clr_tc", tc8, 1'b0);
    tick();
    check_eq("clr_q", q8, 8'h00);
    check_eq("clr_bin", bin8, 8'h00);
    clr8 = 1'b0;
    #1;
    check_eq("load_tc", tc8, 1'b0);
    tick();
    check_eq("load_q", q8, 8'h3C);
    check_eq("load_bin", bin8, 8'h28);
    load8 = 1'b0; en8 = 1'b0;
    tick();
    check_eq("hold_q", q8, 8'h3C);
    check_eq("hold_bin", bin8, 8'h28);

    // async reset mid-count
    load8 = 1'b1; load_val8 = 8'h61;
    tick();
    check_eq("ld41_bin", bin8, 8'h41);
    load8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
    #2;
    rst_n8 = 1'b0;
    #1;
    check_eq("arst_q", q8, 8'h00);
    check_eq("arst_bin", bin8, 8'h00);
    #1;
    rst_n8 = 1'b1;
    tick();
    check_eq("arst_rel_q", q8, 8'h01);
    check_eq("arst_rel_bin", bin8, 8'h01);

    // long up run from zero
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
    hd_bad = 0; gray_bad = 0; bin_bad = 0; tc_cnt = 0; tc_first = -1; tc_second = -1;
    exp_bin = 8'h00;
    for (int k = 0; k < 600; k++) begin
      if (tc8) begin
        tc_cnt++;
        if (tc_first < 0) tc_first = k;
        else if (tc_second < 0) tc_second = k;
      end
      prev_q = q8;
      tick();
      exp_bin = exp_bin + 8'd1;
      if ($countones(q8 ^ prev_q) != 1) hd_bad++;
      if (q8 !== (bin8 ^ (bin8 >> 1))) gray_bad++;
      if (bin8 !== exp_bin) bin_bad++;
    end
    check_eq("run_hamming_bad", hd_bad, 0);
    check_eq("run_gray_bad", gray_bad, 0);
    check_eq("run_bin_bad", bin_bad, 0);
    check_eq("run_tc_count", tc_cnt, 2);
    check_eq("run_tc_first", tc_first, 255);
    check_eq("run_tc_second", tc_second, 511);
    check_eq("run_end_q", q8, 8'h74);
    check_eq("run_end_bin", bin8, 8'h58);
    en8 = 1'b0;

    // saturating 4-bit instance
    load4 = 1'b1; load_val4 = 4'h8;
    tick();
    check_eq("sat_ld_q", q4, 4'h8);
    check_eq("sat_ld_bin", bin4, 4'hF);
    load4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("sat_tc", tc4, 1'b1);
      tick();
      check_eq("sat_q", q4, 4'h8);
      check_eq("sat_bin", bin4, 4'hF);
    end
    up4 = 1'b0;
    #1;
    check_eq("sat_dn_tc", tc4, 1'b0);
    tick();
    check_eq("sat_dn_q", q4, 4'h9);
    check_eq("sat_dn_bin", bin4, 4'hE);
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    #1;
    check_eq("sat_lo_tc", tc4, 1'b1);
    tick();
    check_eq("sat_lo_q", q4, 4'h0);
    check_eq("sat_lo_bin", bin4, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
